dcache_store_queue: RTL

- Commit-side FIFO of architecturally committed stores that drains into one `std_nbdcache` request port, normally port 2 (store port).
- Decouples store commit from data-cache availability, since the cache may stall on misses or MSHR conflicts.
- Drives the cache's two-phase request protocol:
  - index phase: request with `address_index` until grant;
  - tag phase: the cycle after grant, `address_tag` with `tag_valid`.
- Exposes occupancy and a page-offset match used by the load unit for conservative store-to-load hazard detection.

---
 rtl/dcache_store_queue_pkg.sv | 40 ++++
 rtl/st_q_fifo.sv | 88 ++++++++
 rtl/dcache_store_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dcache_store_queue_pkg.sv
// Shared types for the committed-store queue: cache port payloads, queue entry and issue states.
package dcache_store_queue_pkg;

  localparam int unsigned DSQ_PADDR_W = 56;
  localparam int unsigned DSQ_INDEX_W = 12;
  localparam int unsigned DSQ_TAG_W   = DSQ_PADDR_W - DSQ_INDEX_W;
  localparam int unsigned DSQ_DATA_W  = 64;
  localparam int unsigned DSQ_BE_W    = 8;

  typedef struct packed {
    logic [DSQ_PADDR_W-1:0] paddr;
    logic [DSQ_DATA_W-1:0]  data;
    logic [DSQ_BE_W-1:0]    be;
    logic [1:0]             size;
  } st_q_entry_t;

  typedef struct packed {
    logic [DSQ_INDEX_W-1:0] address_index;
    logic [DSQ_TAG_W-1:0]   address_tag;
    logic [DSQ_DATA_W-1:0]  data_wdata;
    logic                   data_req;
    logic                   data_we;
    logic [DSQ_BE_W-1:0]    data_be;
    logic [1:0]             data_size;
    logic                   kill_req;
    logic                   tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                  data_gnt;
    logic                  data_rvalid;
    logic [DSQ_DATA_W-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_TAG  = 1'b1
  } sq_state_e;

endpackage

// File: rtl/st_q_fifo.sv
// Generic circular FIFO with occupancy count and per-slot visibility for hazard compares.
module st_q_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output entry_t                 entries_o [DEPTH],
  output logic [DEPTH-1:0]       occupied_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    occupied_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupied_o[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $error("st_q_fifo: push while full");

endmodule

// File: rtl/dcache_store_queue.sv
// Committed-store queue draining into one data-cache request port via the index/tag handshake.
module dcache_store_queue
  import dcache_store_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PADDR_W = DSQ_PADDR_W,
  parameter int unsigned INDEX_W = DSQ_INDEX_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [PADDR_W-1:0] paddr_i,
  input  logic [63:0]        data_i,
  input  logic [7:0]         be_i,
  input  logic [1:0]         size_i,
  output dcache_req_i_t      req_port_o,
  input  dcache_req_o_t      req_port_i,
  input  logic [11:0]        page_offset_i,
  output logic               page_offset_matches_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  st_q_entry_t        wentry;
  st_q_entry_t        head;
  st_q_entry_t        entries [DEPTH];
  logic [DEPTH-1:0]   occupied;
  logic [CNT_W-1:0]   count;
  logic               fifo_full, fifo_empty, pop;
  sq_state_e          state_q, state_d;
  logic [DSQ_TAG_W-1:0] tag_q, tag_d;
  logic [8:0]         flight_off_q, flight_off_d;
  logic               unused_bits;

  // A store port never consumes read data; the low offset bits are below the compare granule.
  assign unused_bits = ^{page_offset_i[2:0], req_port_i.data_rvalid, req_port_i.data_rdata};

  assign wentry  = '{paddr: DSQ_PADDR_W'(paddr_i), data: data_i, be: be_i, size: size_i};
  assign ready_o = !fifo_full;
  assign full_o  = fifo_full;
  assign empty_o = (count == '0) && (state_q == SQ_IDLE);

  st_q_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (st_q_entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .push_i     (valid_i && ready_o),
    .data_i     (wentry),
    .pop_i      (pop),
    .head_o     (head),
    .entries_o  (entries),
    .occupied_o (occupied),
    .count_o    (count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Issue FSM: index phase from the head entry, tag phase one cycle after grant.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    flight_off_d = flight_off_q;
    pop          = 1'b0;

    req_port_o               = '0;
    req_port_o.data_req      = (count != '0);
    req_port_o.data_we       = 1'b1;
    req_port_o.address_index = DSQ_INDEX_W'(head.paddr[INDEX_W-1:0]);
    req_port_o.data_wdata    = head.data;
    req_port_o.data_be       = head.be;
    req_port_o.data_size     = head.size;
    req_port_o.kill_req      = 1'b0;
    req_port_o.tag_valid     = (state_q == SQ_TAG);
    req_port_o.address_tag   = tag_q;

    if (state_q == SQ_TAG) begin
      state_d = SQ_IDLE;
    end
    if (req_port_i.data_gnt && !fifo_empty) begin
      pop          = 1'b1;
      tag_d        = DSQ_TAG_W'(head.paddr[PADDR_W-1:INDEX_W]);
      flight_off_d = head.paddr[11:3];
      state_d      = SQ_TAG;
    end
    if (clr_i) begin
      pop          = 1'b0;
      state_d      = SQ_IDLE;
      tag_d        = '0;
      flight_off_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SQ_IDLE;
      tag_q        <= '0;
      flight_off_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      flight_off_q <= flight_off_d;
    end
  end

  // Conservative load hazard: queued entries plus the store still in its tag phase.
  always_comb begin
    page_offset_matches_o = (state_q == SQ_TAG) && (flight_off_q == page_offset_i[11:3]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (entries[i].paddr[11:3] == page_offset_i[11:3])) begin
        page_offset_matches_o = 1'b1;
      end
    end
  end

endmodule
